fetch_prefetch: RTL
===================

Name: fetch_prefetch

Overview:
- Parametrised successor to the single-shot fetch unit. Keeps a DEPTH-entry instruction prefetch queue filled from program memory by sequential PC increment.
- Issues at most one outstanding memory request at a time, using a valid/ready handshake.
- Hands instructions to decode through a second valid/ready handshake, tagged with their PC.
- Supports a branch redirect that flushes the queue and squashes any in-flight request.
- Sits between program memory arbitration and the decoder.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, program memory address width.
- PROGRAM_MEM_DATA_BITS, 16, instruction width.
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  permits issuing new memory requests.
- redirect_valid  input  1  branch/jump: flush and restart at redirect_pc.
- redirect_pc  input  ADDR_BITS  new fetch PC.
- program_mem_read_valid  output  1  memory request valid.
- program_mem_read_address  output  ADDR_BITS  request address.
- program_mem_read_ready  input  1  memory accepts the request; data is valid in the same cycle.
- program_mem_read_data  input  DATA_BITS  returned instruction.
- instr_valid  output  1  queue head is valid.
- instr_ready  input  1  decoder consumes the head.
- instruction  output  DATA_BITS  queue head instruction.
- instr_pc  output  ADDR_BITS  PC of the queue head.
- queue_count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset values: all outputs 0, fetch_pc 0, queue empty, state FQ_IDLE.
- FQ_IDLE:
  - Issue condition: enable=1 and queue_count < DEPTH (free space counts the entry a pop frees in the same cycle).
  - On issue, next cycle: read_valid=1, read_address=fetch_pc, state FQ_REQUEST.
- FQ_REQUEST:
  - read_valid and read_address are held stable until read_ready=1.
  - On read_ready: push {data, address} into the queue, fetch_pc <= address+1 (wraps modulo 2^ADDR_BITS).
  - Back-to-back issue: if the issue condition still holds (counting this push and any same-cycle pop), read_valid stays 1 with the new address and the state stays FQ_REQUEST.
  - Otherwise read_valid <= 0 and the state goes to FQ_IDLE.
  - Sustained throughput is one instruction per cycle when memory ready is always 1.
- Latency: enable high with an empty queue gives read_valid 1 cycle later. With same-cycle ready, instr_valid is 2 cycles after enable.
- Pop: instr_valid=1 and instr_ready=1 removes the head. instruction and instr_pc come from registered storage.
- Push and pop in the same cycle on a full queue are legal; the count is unchanged.
- Redirect:
  - Queue cleared next cycle (instr_valid=0, count=0) and fetch_pc <= redirect_pc.
  - No request in flight: go to FQ_IDLE, so issue at redirect_pc can start in the following cycle.
  - Request in flight (read_valid=1, read_ready=0): valid must not drop. Enter FQ_DISCARD, hold the request until read_ready, drop the data, then go to FQ_IDLE.
  - Redirect coincident with read_ready: that data is dropped, read_valid <= 0, then issue at redirect_pc.
- Priorities:
  - Redirect beats pop and push in the same cycle.
  - A redirect during FQ_DISCARD updates fetch_pc only.
- enable low: no new issue. A request already in flight completes normally.
- Reset asserted mid-operation: immediate return to reset values; the in-flight request is abandoned.
- Unused state encodings go to FQ_IDLE.

Decomposition:
- Shared package: fetch_q_state_t enum {FQ_IDLE, FQ_REQUEST, FQ_DISCARD}, alongside the existing fetch state typedef.
- Sub-module fetch_fifo: a synchronous FIFO, parametrised by width and DEPTH.
  - Stores {pc, instruction}.
  - Has a flush input and push/pop ports.
  - Exposes count, full and empty.
  - Pointers wrap modulo DEPTH.

Test Plan:
- Reset, enable=1, memory ready always 1, instr_ready=1, program mem[i]=0x1000+i → pairs (0,0x1000), (1,0x1001), … at one per cycle after the 2-cycle start latency.
- instr_ready=0, DEPTH=4 → exactly 4 requests (addresses 0..3), queue_count=4, read_valid=0. Raise instr_ready for 1 cycle → one pop, then address 4 is requested.
- Memory ready delayed 3 cycles per request → read_address held stable while valid=1; no duplicate or missing pushes.
- redirect_valid with redirect_pc=0x40 while a request to 0x05 is pending and ready is delayed 2 cycles → 0x05 data discarded, queue empty, next request address 0x40, first instr_pc=0x40.
- fetch_pc starts at 0xFE via redirect → requested addresses 0xFE, 0xFF, 0x00; instr_pc values follow the wrap.
- Reset asserted while read_valid=1 and queue_count=3 → all outputs 0 immediately; after release with enable=1, fetch restarts at address 0.

Source files
------------

// File: rtl/fetch_prefetch_pkg.sv
// Shared types for the fetch path: legacy single-shot fetch state and the
// prefetch queue controller state.
package fetch_prefetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE     = 2'd0,
        FETCH_FETCHING = 2'd1,
        FETCH_FETCHED  = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        FQ_IDLE    = 2'd0,
        FQ_REQUEST = 2'd1,
        FQ_DISCARD = 2'd2
    } fetch_q_state_t;

    // Occupancy counters need one bit more than the pointers to represent "full".
    function automatic int count_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs; flush empties it in one cycle.
module fetch_fifo
    import fetch_prefetch_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              dout,
    output logic [count_bits(DEPTH)-1:0]  count,
    output logic                          full,
    output logic                          empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_bits(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    // Entries are reset so the head outputs read as zero out of reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem_reg[gi] <= '0;
            end else if (push && !flush && (wr_ptr_reg == PW'(gi))) begin
                mem_reg[gi] <= din;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assign dout  = mem_reg[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/fetch_prefetch.sv
// Sequential instruction prefetcher: one outstanding memory request, a DEPTH-entry
// queue towards decode, and branch redirect with squash of an in-flight request.
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int DEPTH                 = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              redirect_valid,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0]  redirect_pc,
    output logic                              program_mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]  program_mem_read_address,
    input  logic                              program_mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0]  program_mem_read_data,
    output logic                              instr_valid,
    input  logic                              instr_ready,
    output logic [PROGRAM_MEM_DATA_BITS-1:0]  instruction,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]  instr_pc,
    output logic [$clog2(DEPTH):0]            queue_count
);
    localparam int AW = PROGRAM_MEM_ADDR_BITS;
    localparam int DW = PROGRAM_MEM_DATA_BITS;
    localparam int CW = count_bits(DEPTH);

    fetch_q_state_t state_reg, state_next;
    logic [AW-1:0]  fetch_pc_reg, fetch_pc_next;
    logic           read_valid_reg, read_valid_next;
    logic [AW-1:0]  read_address_reg, read_address_next;

    logic [AW+DW-1:0] fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_en;
    logic             pop_en;
    logic [CW:0]      occupancy_next;
    logic             issue;
    logic [AW-1:0]    pc_after;

    // Redirect wins over both queue ports; the flush discards everything anyway.
    assign pop_en  = !fifo_empty && instr_ready && !redirect_valid;
    assign push_en = (state_reg == FQ_REQUEST) && program_mem_read_ready && !redirect_valid
                     && (!fifo_full || pop_en);

    // Free space is judged on the occupancy after this cycle's push and pop.
    assign occupancy_next = {1'b0, fifo_count} + (CW+1)'(push_en) - (CW+1)'(pop_en);
    assign issue          = enable && (occupancy_next < (CW+1)'(DEPTH));
    assign pc_after       = read_address_reg + AW'(1);

    fetch_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push_en),
        .pop   (pop_en),
        .din   ({read_address_reg, program_mem_read_data}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= FQ_IDLE;
            fetch_pc_reg     <= '0;
            read_valid_reg   <= 1'b0;
            read_address_reg <= '0;
        end else begin
            state_reg        <= state_next;
            fetch_pc_reg     <= fetch_pc_next;
            read_valid_reg   <= read_valid_next;
            read_address_reg <= read_address_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        fetch_pc_next     = fetch_pc_reg;
        read_valid_next   = read_valid_reg;
        read_address_next = read_address_reg;
        case (state_reg)
            FQ_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_pc;
                end else if (issue) begin
                    read_valid_next   = 1'b1;
                    read_address_next = fetch_pc_reg;
                    state_next        = FQ_REQUEST;
                end
            end
            FQ_REQUEST: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_pc;
                    // The request must stay valid until memory takes it.
                    if (program_mem_read_ready) begin
                        read_valid_next = 1'b0;
                        state_next      = FQ_IDLE;
                    end else begin
                        state_next = FQ_DISCARD;
                    end
                end else if (program_mem_read_ready) begin
                    fetch_pc_next = pc_after;
                    if (issue) begin
                        read_address_next = pc_after;
                    end else begin
                        read_valid_next = 1'b0;
                        state_next      = FQ_IDLE;
                    end
                end
            end
            FQ_DISCARD: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_pc;
                end
                if (program_mem_read_ready) begin
                    read_valid_next = 1'b0;
                    state_next      = FQ_IDLE;
                end
            end
            default: begin
                read_valid_next = 1'b0;
                state_next      = FQ_IDLE;
            end
        endcase
    end

    assign program_mem_read_valid   = read_valid_reg;
    assign program_mem_read_address = read_address_reg;
    assign instr_valid              = !fifo_empty;
    assign instruction              = fifo_dout[DW-1:0];
    assign instr_pc                 = fifo_dout[AW+DW-1:DW];
    assign queue_count              = fifo_count;

endmodule
